// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared op codes, FSM states and op-class helpers for the multiply/divide HI/LO unit.
package muldiv_hilo_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_mul(input md_op_e o);
    return (o == MD_MULT) || (o == MD_MULTU);
  endfunction

  function automatic logic op_is_div(input md_op_e o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, shift the quotient bit in.
module muldiv_div_core
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH+1:0] rem_shift;
  logic             fits;

  always_comb begin
    rem_shift = {rem_i, quot_i[WIDTH-1]};
    fits      = (rem_shift >= {2'b00, divisor_i});
    rem_o     = fits ? (rem_shift[WIDTH:0] - {1'b0, divisor_i}) : rem_shift[WIDTH:0];
    quot_o    = {quot_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO register pair, MTHI/MTLO, flush cancel and stall.
// Define MULDIV_FAST_MUL_EN to make MULT/MULTU single-cycle combinational multiplies.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             mul_q, mul_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  md_op_e           op_e;
  logic             is_mul, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             launch, launch_fast, launch_iter;
  logic [WIDTH:0]   mul_sum, div_rem, step_rem;
  logic [WIDTH-1:0] div_quot, step_quot, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix, fast_prod;

  muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (div_rem),
    .quot_o    (div_quot)
  );

  always_comb begin
    op_e   = md_op_e'(op);
    is_mul = op_is_mul(op_e);
    is_div = op_is_div(op_e);
    a_neg  = op_is_signed(op_e) & a[WIDTH-1];
    b_neg  = op_is_signed(op_e) & b[WIDTH-1];
    abs_a  = a_neg ? -a : a;
    abs_b  = b_neg ? -b : b;
    launch      = (state_q == MD_IDLE) && start && !cancel && (is_mul || is_div);
    launch_fast = launch && is_mul && FastMul;
    launch_iter = launch && !launch_fast;
  end

  if (FastMul) begin : g_fast_mul
    always_comb begin
      fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
      if (a_neg ^ b_neg) fast_prod = -fast_prod;
    end
  end else begin : g_iter_mul
    assign fast_prod = '0;
  end

  // Shared datapath: {rem_q, quot_q} is the 2*WIDTH+1 accumulator for both ops.
  // Mul shifts right adding the multiplicand on the multiplier LSB; div steps the core.
  always_comb begin
    mul_sum   = rem_q + (quot_q[0] ? {1'b0, dvsr_q} : '0);
    step_rem  = mul_q ? {1'b0, mul_sum[WIDTH:1]} : div_rem;
    step_quot = mul_q ? {mul_sum[0], quot_q[WIDTH-1:1]} : div_quot;
    prod_fix  = {step_rem[WIDTH-1:0], step_quot};
    if (neg_res_q) prod_fix = -prod_fix;
    quo_fix   = neg_res_q ? -step_quot : step_quot;
    rem_fix   = neg_rem_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    a_d       = a_q;
    mul_d     = mul_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall     = launch_iter || (state_q == MD_BUSY);
    done      = (state_q == MD_DONE);

    case (state_q)
      MD_IDLE: begin
        if (launch_fast) begin
          hi_d    = fast_prod[2*WIDTH-1:WIDTH];
          lo_d    = fast_prod[WIDTH-1:0];
          state_d = MD_DONE;
        end else if (launch_iter) begin
          mul_d     = is_mul;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (b == '0);
          a_d       = a;
          dvsr_d    = is_mul ? abs_a : abs_b;
          quot_d    = is_mul ? abs_b : abs_a;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = MD_BUSY;
        end else if (start && !cancel && (op_e == MD_MTHI)) begin
          hi_d = a;
        end else if (start && !cancel && (op_e == MD_MTLO)) begin
          lo_d = a;
        end
      end
      MD_BUSY: begin
        if (cancel) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + 1'b1;
          // Last step and sign fix-up commit on the same edge that enters DONE.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = MD_DONE;
            if (mul_q) begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end else if (div0_q) begin
              hi_d = a_q;
              lo_d = '1;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      a_q       <= '0;
      mul_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      a_q       <= a_d;
      mul_q     <= mul_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: reference results from plain 64-bit arithmetic.
`timescale 1ns/1ps
module tb_muldiv_hilo_unit;
  import muldiv_hilo_unit_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         stall, done;
  logic [W-1:0] hi_o, lo_o;

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .stall(stall), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int unsigned  at;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_model(input md_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      MD_MULT:  p = sx * sy;
      MD_MULTU: p = {32'b0, x} * {32'b0, y};
      MD_DIV, MD_DIVU: begin
        if (y == '0) p = {x, 32'hFFFF_FFFF};
        else begin
          if (o == MD_DIVU) begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
          end
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi_result", hi_o, e.hi);
        chk("lo_result", lo_o, e.lo);
        chk("done_cycle", cyc, e.at);
        chk("stall_in_done", stall, 0);
      end
    end
  end

  task automatic run_op(input md_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] r;
    bit fast, seen;
    fast = FAST && (o == MD_MULT || o == MD_MULTU);
    r = ref_model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back('{hi: r[63:32], lo: r[31:0], at: cyc + (fast ? 1 : W + 1)});
    @(negedge clk);
    chk("stall_c0", stall, fast ? 0 : 1);
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(W) + 4 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else chk("stall_busy", stall, fast ? 0 : 1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done for op %0d", o);
      sb.delete();
    end
    m_hi = r[63:32];
    m_lo = r[31:0];
    @(posedge clk); #1;
  endtask

  task automatic move_to(input md_op_e o, input logic [W-1:0] x);
    start = 1'b1; op = o; a = x;
    #1 chk("mt_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
    if (o == MD_MTHI) m_hi = x; else m_lo = x;
    chk("mt_hi", hi_o, m_hi);
    chk("mt_lo", lo_o, m_lo);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    md_op_e ops[4];
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    #2;
    chk("reset_stall", stall, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi_o, 0);
    chk("reset_lo", lo_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(MD_DIVU, 32'd100, 32'd7);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'h0000_1234, 32'd0);
    run_op(MD_DIV, 32'hFFFF_FFFB, 32'd0);
    run_op(MD_DIV, 32'd7, 32'hFFFF_FFFE);

    // MTHI preload, DIV cancelled at c10, MTLO right after.
    move_to(MD_MTHI, 32'hAA);
    start = 1'b1; op = MD_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_idle_stall", stall, 0);
    chk("cancel_hi_kept", hi_o, 32'hAA);
    move_to(MD_MTLO, 32'h55);
    repeat (W + 4) @(posedge clk);
    #1 chk("cancel_hi_after", hi_o, 32'hAA);

    // start together with cancel is dropped.
    start = 1'b1; op = MD_DIVU; a = 32'd50; b = 32'd5; cancel = 1'b1;
    #1 chk("cancel_start_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_idle", stall, 0);
    repeat (W + 4) @(posedge clk);
    #1 chk("cancel_start_lo", lo_o, 32'h55);

    // Async reset mid-BUSY.
    start = 1'b1; op = MD_DIVU; a = 32'd999; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 chk("busy_before_rst", stall, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_stall", stall, 0);
    chk("rst_async_done", done, 0);
    chk("rst_async_hi", hi_o, 0);
    chk("rst_async_lo", lo_o, 0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1 rst = 1'b0;
    run_op(MD_DIVU, 32'd1000, 32'd33);

    for (int n = 0; n < 40; n++) begin
      run_op(ops[$urandom_range(0, 3)], pick_operand(), pick_operand());
    end

    chk("idle_hi", hi_o, m_hi);
    chk("idle_lo", lo_o, m_lo);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
